// File: rtl/bpred_pkg.sv
// Shared helpers for the branch target buffer: counter reset/allocate
// values and PC-to-index/tag slicing. Everything that depends on the
// table geometry is supplied by the caller, so the package needs no parameters.
package bpred_pkg;

   // PC bits below this position are ignored; instructions are word aligned.
   localparam int unsigned ADDR_LSB = 2;

   // Counter value given to a newly allocated taken branch.
   function automatic logic [63:0] weak_t(input int unsigned cnt_w);
      return 64'd1 << (cnt_w - 1);
   endfunction

   // Counter value held by every entry after reset.
   function automatic logic [63:0] weak_nt(input int unsigned cnt_w);
      return (64'd1 << (cnt_w - 1)) - 64'd1;
   endfunction

   // Table index taken from the bits just above the word offset.
   function automatic logic [63:0] pc_index(input logic [63:0] pc, input int unsigned idx_w);
      return (pc >> ADDR_LSB) & ((64'd1 << idx_w) - 64'd1);
   endfunction

   // Tag is every PC bit above the index.
   function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned idx_w);
      return pc >> (idx_w + ADDR_LSB);
   endfunction

endpackage

// File: rtl/bpred_sat_ctr.sv
// Saturating up/down next-value logic for one direction counter.
// Holds at zero when counting down and at all-ones when counting up.
module bpred_sat_ctr #(
   parameter int CNT_W = 2
) (
   input  logic [CNT_W-1:0] cnt_i,
   input  logic             up_i,
   output logic [CNT_W-1:0] cnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Step towards taken or not-taken, refusing to wrap at either end.
   always_comb begin
      cnt_o = cnt_i;
      if (up_i) begin
         if (cnt_i != CNT_MAX) cnt_o = cnt_i + CNT_ONE;
      end else begin
         if (cnt_i != '0) cnt_o = cnt_i - CNT_ONE;
      end
   end

endmodule

// File: rtl/bpred_btb.sv
// Branch target buffer with per-entry saturating direction counters.
// Predicts next PC combinationally from fetch_pc, is trained from execute,
// and flags mispredicts with the corrected PC in the same cycle.
// Optional feature macro: BPRED_STATS_EN adds branch/mispredict counters.
module bpred_btb
   import bpred_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int XLEN    = 32,
   parameter int CNT_W   = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] fetch_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   output logic            pred_hit,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_pred_taken,
   input  logic [XLEN-1:0] upd_pred_target,
   output logic            mispredict,
   output logic [XLEN-1:0] redirect_pc,
   input  logic            bt_flush
`ifdef BPRED_STATS_EN
   ,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
`endif
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;
   localparam logic [CNT_W-1:0] WEAK_T_C  = CNT_W'(weak_t(CNT_W));
   localparam logic [CNT_W-1:0] WEAK_NT_C = CNT_W'(weak_nt(CNT_W));
   localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(4);

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  target;
      logic [CNT_W-1:0] cnt;
   } entry_t;

   entry_t table_q [ENTRIES];
   entry_t table_d [ENTRIES];

   logic [IDX_W-1:0] fetch_idx;
   logic [TAG_W-1:0] fetch_tag;
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_hit;
   logic [CNT_W-1:0] upd_cnt;
   logic [CNT_W-1:0] ctr_next;

   assign fetch_idx = IDX_W'(pc_index(64'(fetch_pc), IDX_W));
   assign fetch_tag = TAG_W'(pc_tag(64'(fetch_pc), IDX_W));
   assign upd_idx   = IDX_W'(pc_index(64'(upd_pc), IDX_W));
   assign upd_tag   = TAG_W'(pc_tag(64'(upd_pc), IDX_W));

   // Lookup straight from the registered table; forced to a miss while in reset.
   always_comb begin
      pred_hit    = reset && table_q[fetch_idx].valid && (table_q[fetch_idx].tag == fetch_tag);
      pred_taken  = pred_hit && table_q[fetch_idx].cnt[CNT_W-1];
      pred_target = pred_taken ? table_q[fetch_idx].target : fetch_pc + PC_STEP;
   end

   // Resolve whether the execute-stage branch hits the entry it would train.
   always_comb begin
      upd_hit = table_q[upd_idx].valid && (table_q[upd_idx].tag == upd_tag);
      upd_cnt = table_q[upd_idx].cnt;
   end

   bpred_sat_ctr #(
      .CNT_W (CNT_W)
   ) u_sat_ctr (
      .cnt_i (upd_cnt),
      .up_i  (upd_taken),
      .cnt_o (ctr_next)
   );

   // Next table contents: flush beats training, and a flushed cycle drops the update.
   always_comb begin
      table_d = table_q;
      if (bt_flush) begin
         for (int i = 0; i < ENTRIES; i++) table_d[i].valid = 1'b0;
      end else if (upd_valid) begin
         if (upd_hit) begin
            table_d[upd_idx].cnt = ctr_next;
            if (upd_taken) table_d[upd_idx].target = upd_target;
         end else if (upd_taken) begin
            table_d[upd_idx] = '{valid: 1'b1, tag: upd_tag, target: upd_target, cnt: WEAK_T_C};
         end
      end
   end

   // Table register; reset empties every entry and parks counters at weakly not-taken.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: WEAK_NT_C};
         end
      end else begin
         table_q <= table_d;
      end
   end

   // Mispredict detection and the corrected next PC for the redirect.
   always_comb begin
      mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                  (upd_taken && (upd_target != upd_pred_target)));
      redirect_pc = upd_taken ? upd_target : upd_pc + PC_STEP;
   end

`ifdef BPRED_STATS_EN
   logic [31:0] stat_branches_q;
   logic [31:0] stat_branches_d;
   logic [31:0] stat_mispredicts_q;
   logic [31:0] stat_mispredicts_d;

   // Saturating event counters; only reset clears them, flush does not.
   always_comb begin
      stat_branches_d    = stat_branches_q;
      stat_mispredicts_d = stat_mispredicts_q;
      if (upd_valid && (stat_branches_q != '1)) stat_branches_d = stat_branches_q + 32'd1;
      if (mispredict && (stat_mispredicts_q != '1)) stat_mispredicts_d = stat_mispredicts_q + 32'd1;
   end

   // Statistics registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stat_branches_q    <= '0;
         stat_mispredicts_q <= '0;
      end else begin
         stat_branches_q    <= stat_branches_d;
         stat_mispredicts_q <= stat_mispredicts_d;
      end
   end

   assign stat_branches    = stat_branches_q;
   assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: doc/bpred_btb.md
# bpred_btb

Parametrised branch target buffer with saturating-counter direction prediction for the pipelined RISC-V core. Sits beside the fetch PC register: it predicts next-PC in the same cycle from `fetch_pc`. It is trained from the execute stage, where it also flags mispredicts. Its redirect output replaces the unconditional flush-on-taken-branch behaviour of the earlier core.

## Interface
- `ENTRIES`, 16: table depth; power of two, ≥2; `IDX_W = $clog2(ENTRIES)`.
- `XLEN`, 32: address/target width.
- `CNT_W`, 2: direction counter width, ≥1.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-low.
- `fetch_pc` in XLEN: current fetch address.
- `pred_taken` out 1: predicted taken.
- `pred_target` out XLEN: predicted next PC.
- `pred_hit` out 1: `fetch_pc` hits a valid entry.
- `upd_valid` in 1: execute stage resolves a control-transfer this cycle, already gated by stall/flush.
- `upd_pc` in XLEN: PC of the resolved instruction.
- `upd_taken` in 1: actual direction.
- `upd_target` in XLEN: actual target.
- `upd_pred_taken` in 1, `upd_pred_target` in XLEN: prediction piped down with the instruction.
- `mispredict` out 1: redirect required.
- `redirect_pc` out XLEN: correct next PC.
- `bt_flush` in 1: invalidate entire table (fence.i, context change).
- `stat_branches`, `stat_mispredicts` out 32 each: present only under `BPRED_STATS_EN`.

## Operation
- Index = `pc[IDX_W+1:2]`; tag = `pc[XLEN-1:IDX_W+2]`. Bits [1:0] are ignored.
- Entry fields: valid, tag, target, counter.
- Lookup, combinational from registered table:
  - `pred_hit` = valid && tag match.
  - `pred_taken` = `pred_hit` && counter MSB.
  - `pred_target` = entry target if `pred_taken`, else `fetch_pc + 4` (mod 2^XLEN).
- Update when `upd_valid`, index/tag from `upd_pc`:
  - Hit: counter saturating +1 if taken, −1 if not; no wrap at 0 or 2^CNT_W−1. Target overwritten with `upd_target` only if taken.
  - Miss and taken: allocate/replace. Set valid=1, tag, target, counter = WEAK_T (2^(CNT_W−1)).
  - Miss and not taken: no change.
- `mispredict` = `upd_valid` && (`upd_taken` ≠ `upd_pred_taken` || (`upd_taken` && `upd_target` ≠ `upd_pred_target`)).
- `redirect_pc` = `upd_taken` ? `upd_target` : `upd_pc + 4`. The value is don't-care when `mispredict`=0.
- `bt_flush`: all valid bits cleared next edge; counters and targets untouched.
- Priority per edge: reset > `bt_flush` > update. An update in the same cycle as a flush is dropped.

## Timing
- Lookup latency 0 cycles, purely combinational from state.
- Update is visible to lookup from the cycle after the edge. A same-cycle lookup of the same index sees old contents; there is no bypass.
- `mispredict`/`redirect_pc` are combinational, same cycle as `upd_valid`.
- Reset state: all valid=0, counters = WEAK_NT (2^(CNT_W−1)−1), stats=0.
- Outputs while in reset: `pred_hit`=0, `pred_taken`=0, `pred_target`=`fetch_pc+4`. `mispredict` still follows its inputs; the core gates `upd_valid` during reset.
- Reset asserted mid-training discards all state on that edge.

## Configuration
- `BPRED_STATS_EN` defined:
  - `stat_branches` increments on every `upd_valid`.
  - `stat_mispredicts` increments on every `mispredict`.
  - Both are 32-bit, saturate at all-ones, cleared only by reset, and are unaffected by `bt_flush`.
- Undefined: both ports and their counters are absent.

## Structure
- `bpred_pkg`: entry struct typedef (parametrised via XLEN/IDX_W in the module), `WEAK_T`/`WEAK_NT` constants, index/tag extraction functions.
- One sub-module, `bpred_sat_ctr`: CNT_W-bit saturating up/down next-value logic, instantiated once in the update path.

## Test plan
- Reset, then lookup 0x100: `pred_hit`=0, `pred_taken`=0, `pred_target`=0x104.
- Taken-branch allocate:
  - Stimulus: update pc 0x100, taken, target 0x40, pred_taken=0.
  - Same cycle: `mispredict`=1, `redirect_pc`=0x40.
  - Next cycle, lookup 0x100: hit, `pred_taken`=1, `pred_target`=0x40.
- Counter saturation and hysteresis (CNT_W=2):
  - Five taken updates on 0x100 leave the counter at 3.
  - Two not-taken updates then give `pred_taken`=0 (counter 1).
  - Two more not-taken updates hold the counter at 0, not 3.
- Alias replace (ENTRIES=16): allocate 0x100, then taken update of 0x140 (same index, different tag). Lookup 0x100 then misses; 0x140 hits with counter WEAK_T.
- Flush vs update same cycle: `bt_flush`=1 with taken update 0x200. Next cycle both 0x100 and 0x200 miss.
- `BPRED_STATS_EN`: 10 updates, 3 mispredicted → stats 10/3; `bt_flush` leaves them at 10/3; reset zeroes both.
